// File: rtl/udp_payload_feeder_if.sv
// Sample-in / payload-out bundle between acquisition, feeder and UDP sender.
// Latency: n/a (signal bundle only).
// Backpressure: none on samples (overflow drops); payload bytes advance on i_send_rd.
// Ports:
//   i_sample[15:0], i_sample_vld : sample word and its write strobe
//   i_send_sync                  : active-low packet-boundary sync from the Ethernet top
//   i_send_rd                    : byte consume strobe from the UDP sender
//   o_send_data[7:0]             : current payload byte
//   o_overflow                   : sticky sample-drop flag
interface udp_payload_feeder_if;
  logic [15:0] i_sample;
  logic        i_sample_vld;
  logic        i_send_sync;
  logic        i_send_rd;
  logic [7:0]  o_send_data;
  logic        o_overflow;

  // master: acquisition + UDP sender side
  modport master (
    output i_sample, i_sample_vld, i_send_sync, i_send_rd,
    input  o_send_data, o_overflow
  );

  // slave: the payload feeder
  modport slave (
    input  i_sample, i_sample_vld, i_send_sync, i_send_rd,
    output o_send_data, o_overflow
  );
endinterface

// File: rtl/udp_payload_feeder.sv
// Double-banked sample buffer serving one header+payload packet per send-sync edge.
// Latency: o_send_data is registered; a byte consumed on i_send_rd is replaced next cycle.
// Backpressure: none upstream -- samples arriving with no free bank are dropped and counted.
// Ports:
//   clk, rst : TX clock, asynchronous active-high reset
//   bus      : udp_payload_feeder_if.slave (samples in, sync/read strobes in, bytes out)
module udp_payload_feeder #(
  parameter int          SAMPLES_PER_PKT = 512,
  parameter int          HDR_BYTES       = 16,
  parameter logic [15:0] MAGIC           = 16'hA55A
) (
  input  logic                clk,
  input  logic                rst,
  udp_payload_feeder_if.slave bus
);
  localparam int PKT_LEN = HDR_BYTES + 2 * SAMPLES_PER_PKT;
  localparam int PW      = $clog2(SAMPLES_PER_PKT);
  localparam int IW      = $clog2(PKT_LEN + 1);

  typedef enum logic {W_FILL, W_DROP} wr_state_t;

  // writer side
  wr_state_t     wr_state;
  logic          wr_bank;
  logic [PW-1:0] wr_ptr;
  logic [1:0]    bank_full;
  logic [1:0]    bank_held;
  logic          sync_q;
  logic [15:0]   drop_cnt;
  logic          ovf_since;
  logic          ovf_q;

  // reader side
  logic          pkt_valid;
  logic          rd_bank;
  logic          hdr_ovf;
  logic [31:0]   seq;
  logic [31:0]   hdr_seq;
  logic [15:0]   hdr_drop;
  logic [IW-1:0] rd_idx;
  logic [7:0]    cur_lo;
  logic [15:0]   rdata;
  logic [7:0]    send_data_q;

  logic [15:0]   mem [2*SAMPLES_PER_PKT];

  logic          boundary, wr_fire, wr_last, drop, other_empty;
  logic          pick_any, pick_bank;
  logic [1:0]    fill_now, full_eff, pick_oh;
  logic [IW-1:0] nxt_idx;
  logic          nxt_lo, nxt_pay;
  logic [7:0]    nxt_byte, hdr_byte;
  logic [15:0]   hdr_cnt;
  logic [PW-1:0] ra_ptr;

  assign boundary    = sync_q & ~bus.i_send_sync;
  assign wr_fire     = bus.i_sample_vld && (wr_state == W_FILL);
  assign wr_last     = wr_fire && (wr_ptr == PW'(SAMPLES_PER_PKT - 1));
  assign drop        = bus.i_sample_vld && (wr_state == W_DROP);
  assign other_empty = ~bank_full[~wr_bank] & ~bank_held[~wr_bank];

  // A bank completing in the boundary cycle already counts as FULL for that boundary.
  assign fill_now = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_eff = bank_full | fill_now;
  assign pick_any = |full_eff;
  // The writer only leaves a bank once it is full, so with both full the writer's
  // current bank is the newer one.
  assign pick_bank = (full_eff == 2'b11) ? ~wr_bank : full_eff[1];
  assign pick_oh   = pick_any ? (2'b01 << pick_bank) : 2'b00;

  assign bus.o_send_data = send_data_q;
  assign bus.o_overflow  = ovf_q;

  always_comb begin
    nxt_idx = rd_idx + IW'(1);
    nxt_lo  = 1'(nxt_idx - IW'(HDR_BYTES));
    nxt_pay = (nxt_idx >= IW'(HDR_BYTES)) && (nxt_idx < IW'(PKT_LEN));
    // Read-ahead: while showing sample s, fetch sample s+1 so its MSB byte is in
    // rdata when the consumer moves onto it (sample 0 is fetched during the header).
    ra_ptr  = (rd_idx < IW'(HDR_BYTES)) ? '0
            : PW'((rd_idx - IW'(HDR_BYTES)) >> 1) + PW'(1);
    hdr_cnt  = pkt_valid ? 16'(SAMPLES_PER_PKT) : 16'h0000;
    hdr_byte = 8'h00;
    if (nxt_idx < IW'(16)) begin
      case (4'(nxt_idx))
        4'd0:    hdr_byte = MAGIC[15:8];
        4'd1:    hdr_byte = MAGIC[7:0];
        4'd2:    hdr_byte = hdr_seq[31:24];
        4'd3:    hdr_byte = hdr_seq[23:16];
        4'd4:    hdr_byte = hdr_seq[15:8];
        4'd5:    hdr_byte = hdr_seq[7:0];
        4'd6:    hdr_byte = hdr_cnt[15:8];
        4'd7:    hdr_byte = hdr_cnt[7:0];
        4'd8:    hdr_byte = hdr_drop[15:8];
        4'd9:    hdr_byte = hdr_drop[7:0];
        4'd10:   hdr_byte = {6'b0, hdr_ovf, pkt_valid};
        4'd11:   hdr_byte = {7'b0, rd_bank};
        default: hdr_byte = 8'h00;
      endcase
    end
    nxt_byte = 8'h00;
    if (nxt_idx < IW'(HDR_BYTES))  nxt_byte = hdr_byte;
    else if (nxt_pay && pkt_valid) nxt_byte = nxt_lo ? cur_lo : rdata[15:8];
  end

  // Sample RAM: the writer never targets the bank the reader holds.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_ptr}] <= bus.i_sample;
    rdata <= mem[{rd_bank, ra_ptr}];
  end

  // Writer FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= W_FILL;
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
    end else begin
      case (wr_state)
        W_FILL: if (wr_fire) begin
          if (!wr_last) begin
            wr_ptr <= wr_ptr + PW'(1);
          end else if (other_empty) begin
            wr_bank <= ~wr_bank;
            wr_ptr  <= '0;
          end else begin
            wr_state <= W_DROP;
          end
        end
        W_DROP: if (other_empty) begin
          wr_state <= W_FILL;
          wr_bank  <= ~wr_bank;
          wr_ptr   <= '0;
        end
        default: wr_state <= W_FILL;
      endcase
    end
  end

  // Bank ownership, drop accounting, sync edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= 2'b00;
      bank_held <= 2'b00;
      sync_q    <= 1'b1;
      drop_cnt  <= 16'h0000;
      ovf_since <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q <= bus.i_send_sync;
      ovf_q  <= ovf_q | drop;
      if (boundary) begin
        bank_full <= full_eff & ~pick_oh;
        bank_held <= pick_oh;
        // counters were latched into the header; a drop this cycle belongs to the next one
        drop_cnt  <= {15'd0, drop};
        ovf_since <= drop;
      end else begin
        bank_full <= full_eff;
        if (drop) begin
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          ovf_since <= 1'b1;
        end
      end
    end
  end

  // Reader: header latch and byte stream
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_valid   <= 1'b0;
      rd_bank     <= 1'b0;
      hdr_seq     <= 32'd0;
      hdr_drop    <= 16'h0000;
      hdr_ovf     <= 1'b0;
      seq         <= 32'd0;
      rd_idx      <= '0;
      cur_lo      <= 8'h00;
      send_data_q <= MAGIC[15:8];
    end else if (boundary) begin
      pkt_valid   <= pick_any;
      rd_bank     <= pick_bank;
      hdr_seq     <= seq;
      hdr_drop    <= drop_cnt;
      hdr_ovf     <= ovf_since;
      if (pick_any) seq <= seq + 32'd1;
      rd_idx      <= '0;
      send_data_q <= MAGIC[15:8];
    end else if (bus.i_send_rd && (rd_idx < IW'(PKT_LEN))) begin
      rd_idx      <= nxt_idx;
      send_data_q <= nxt_byte;
      if (nxt_pay && !nxt_lo) cur_lo <= rdata[7:0];
    end
  end
endmodule
